tdm_demux_1x4: RTL and testbench

Receive-side counterpart of the 4:1 multiplexer: a framed time-division demultiplexer that takes the serial stream produced by scanning a 4:1 mux through selects 00, 01, 10, 11 and rebuilds the 4-channel word. It sits at the far end of a serial link fed by a mux-based TDM transmitter. Its outputs are a parallel word with a one-cycle valid strobe, plus a frame-sync error flag.

---
 rtl/tdm_demux_1x4.sv | 74 +++++++
 tb/tb_tdm_demux_1x4.sv | 109 ++++++++++
 2 files changed

// File: rtl/tdm_demux_1x4.sv
// tdm_demux_1x4: framed 1:4 TDM demultiplexer rebuilding a 4-channel word from a serial slot stream
module tdm_demux_1x4 #(
  parameter int CH_W = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CH_W-1:0]     din,
  input  logic                sync,
  input  logic                en,
  output logic [0:4*CH_W-1]   a,
  output logic [0:1]          s,
  output logic                valid,
  output logic                sync_err
);
  typedef enum logic {HUNT, RUN} state_t;
  state_t state, state_n;
  logic [CH_W-1:0] sh0, sh1, sh2, sh0_n, sh1_n, sh2_n;
  logic [0:4*CH_W-1] a_n;
  logic [0:1] s_n;
  logic valid_n, err_n;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= HUNT;
      s        <= '0;
      sh0      <= '0;
      sh1      <= '0;
      sh2      <= '0;
      a        <= '0;
      valid    <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      state    <= state_n;
      s        <= s_n;
      sh0      <= sh0_n;
      sh1      <= sh1_n;
      sh2      <= sh2_n;
      a        <= a_n;
      valid    <= valid_n;
      sync_err <= err_n;
    end
  end
  // sync always restarts at slot 0; an early sync in RUN also flags the dropped frame
  always_comb begin
    state_n = state;
    s_n     = s;
    sh0_n   = sh0;
    sh1_n   = sh1;
    sh2_n   = sh2;
    a_n     = a;
    valid_n = 1'b0;
    err_n   = 1'b0;
    if (en) begin
      if (sync) begin
        err_n   = (state == RUN) && (s != 2'd0);
        sh0_n   = din;
        s_n     = 2'd1;
        state_n = RUN;
      end else if (state == RUN) begin
        if (s == 2'd0) begin
          err_n   = 1'b1;
          state_n = HUNT;
        end else if (s == 2'd3) begin
          a_n     = {sh0, sh1, sh2, din};
          valid_n = 1'b1;
          s_n     = 2'd0;
        end else begin
          sh1_n = (s == 2'd1) ? din : sh1;
          sh2_n = (s == 2'd2) ? din : sh2;
          s_n   = s + 2'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_tdm_demux_1x4.sv
// tb_tdm_demux_1x4: table-driven directed checks of the framed 1:4 TDM demultiplexer
module tb_tdm_demux_1x4;
  logic clk = 1'b0;
  logic rst_n, sync, en, valid, sync_err;
  logic [0:0] din;
  logic [0:3] a;
  logic [0:1] s;
  int passed = 0, total = 0;

  typedef struct {
    logic en, sync, din;
    logic [3:0] a;
    logic [1:0] s;
    logic v, e;
  } vec_t;
  vec_t tbl[$];

  tdm_demux_1x4 #(.CH_W(1)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .sync(sync), .en(en),
    .a(a), .s(s), .valid(valid), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic chk_all(input string tag, input logic [3:0] ea, input logic [1:0] es,
                         input logic ev, input logic ee);
    chk({tag, " a"}, a, ea);
    chk({tag, " s"}, {2'b00, s}, {2'b00, es});
    chk({tag, " valid"}, {3'b000, valid}, {3'b000, ev});
    chk({tag, " sync_err"}, {3'b000, sync_err}, {3'b000, ee});
  endtask

  task automatic step(input logic e, input logic sy, input logic d);
    @(negedge clk);
    en = e; sync = sy; din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic e, sy, d, input logic [3:0] ea, input logic [1:0] es,
                     input logic ev, ee);
    vec_t v;
    v.en = e; v.sync = sy; v.din = d; v.a = ea; v.s = es; v.v = ev; v.e = ee;
    tbl.push_back(v);
  endtask

  initial begin
    // basic frame 0,1,0,1 then 1,1,0,0
    add(1,1,0, 4'b0000,2'd1,0,0); add(1,0,1, 4'b0000,2'd2,0,0);
    add(1,0,0, 4'b0000,2'd3,0,0); add(1,0,1, 4'b0101,2'd0,1,0);
    add(1,1,1, 4'b0101,2'd1,0,0); add(1,0,1, 4'b0101,2'd2,0,0);
    add(1,0,0, 4'b0101,2'd3,0,0); add(1,0,0, 4'b1100,2'd0,1,0);
    // gapped strobe, same 1,1,0,0 frame
    add(1,1,1, 4'b1100,2'd1,0,0);
    for (int i = 0; i < 3; i++) add(0,1,0, 4'b1100,2'd1,0,0);
    add(1,0,1, 4'b1100,2'd2,0,0);
    for (int i = 0; i < 3; i++) add(0,0,0, 4'b1100,2'd2,0,0);
    add(1,0,0, 4'b1100,2'd3,0,0);
    for (int i = 0; i < 3; i++) add(0,0,1, 4'b1100,2'd3,0,0);
    add(1,0,0, 4'b1100,2'd0,1,0);
    add(0,0,0, 4'b1100,2'd0,0,0);
    // early sync: 1,1 aborted, fresh 0,1,0,1
    add(1,1,1, 4'b1100,2'd1,0,0); add(1,0,1, 4'b1100,2'd2,0,0);
    add(1,1,0, 4'b1100,2'd1,0,1); add(1,0,1, 4'b1100,2'd2,0,0);
    add(1,0,0, 4'b1100,2'd3,0,0); add(1,0,1, 4'b0101,2'd0,1,0);
    // missing sync drops to HUNT; sync-less data ignored until next sync
    add(1,0,1, 4'b0101,2'd0,0,1); add(1,0,1, 4'b0101,2'd0,0,0);
    add(1,0,0, 4'b0101,2'd0,0,0); add(1,1,1, 4'b0101,2'd1,0,0);
    add(1,0,1, 4'b0101,2'd2,0,0); add(1,0,1, 4'b0101,2'd3,0,0);
    add(1,0,1, 4'b1111,2'd0,1,0);

    en = 0; sync = 0; din = 0; rst_n = 0;
    #12;
    chk_all("reset", 4'b0000, 2'd0, 0, 0);
    rst_n = 1;
    for (int i = 0; i < 5; i++) step(0, 0, 1);
    chk_all("idle", 4'b0000, 2'd0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].en, tbl[i].sync, tbl[i].din);
      chk_all($sformatf("vec%0d", i), tbl[i].a, tbl[i].s, tbl[i].v, tbl[i].e);
    end

    // async reset mid-frame, between clock edges
    step(1, 1, 1);
    step(1, 0, 0);
    chk_all("pre_rst", 4'b1111, 2'd2, 0, 0);
    #2 rst_n = 0;
    #1 chk_all("async_rst", 4'b0000, 2'd0, 0, 0);
    #1 rst_n = 1;
    step(1, 0, 1);
    chk_all("post_rst_hunt", 4'b0000, 2'd0, 0, 0);
    step(1, 1, 1); step(1, 0, 0); step(1, 0, 1);
    chk_all("post_rst_s3", 4'b0000, 2'd3, 0, 0);
    step(1, 0, 0);
    chk_all("post_rst_frame", 4'b1010, 2'd0, 1, 0);
    step(0, 0, 0);
    chk_all("post_rst_hold", 4'b1010, 2'd0, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
